wm_scheduler: RTL and testbench

Program scheduler and phase timer for the washing-machine controller. It accepts a wash-program request with an optional delayed start and drives the controller's `start` input. It times the two motor phases (soap wash, water rinse) and the spin phase by watching the controller's `motor_on` and `drain_value_on` outputs, and returns `cycle_timeout` and `spin_timeout`. It sits between the user panel and the controller and replaces free-running external timers.

---
 rtl/wm_pkg.sv | 45 ++++
 rtl/wm_tick_gen.sv | 28 ++
 rtl/wm_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_wm_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared types and constants for the washing-machine program scheduler.
// Holds the FSM state encoding, program and phase codes, and per-program durations.
package wm_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DELAY,
      ST_START,
      ST_WAIT_MOTOR,
      ST_RUN_CYCLE,
      ST_TIMEOUT_C,
      ST_WAIT_SPIN,
      ST_RUN_SPIN,
      ST_TIMEOUT_S,
      ST_FAULT
   } state_t;

   typedef enum logic [1:0] {
      PROG_NORMAL = 2'd0,
      PROG_QUICK  = 2'd1,
      PROG_HEAVY  = 2'd2,
      PROG_RSVD   = 2'd3
   } prog_t;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_WASH  = 2'd1,
      PH_RINSE = 2'd2,
      PH_SPIN  = 2'd3
   } phase_t;

   // Indexed by program code; the reserved slot is never latched.
   localparam logic [7:0] WASH_T  [4] = '{8'd40, 8'd15, 8'd80, 8'd0};
   localparam logic [7:0] RINSE_T [4] = '{8'd20, 8'd8,  8'd40, 8'd0};
   localparam logic [7:0] SPIN_T  [4] = '{8'd20, 8'd10, 8'd30, 8'd0};

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] sat_dec(input logic [7:0] v);
      return (v == 8'h00) ? v : v - 8'd1;
   endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
// The counter restarts from zero on reset so tick alignment is reproducible.
module wm_tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] tick_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick_cnt == LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

   assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/wm_scheduler.sv
// Program scheduler and phase timer sitting between the user panel and the
// washing-machine controller; all outputs decode from registered state.
module wm_scheduler
   import wm_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int WDOG_TICKS = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       prog_valid,
   output logic       prog_ready,
   input  logic [1:0] prog_sel,
   input  logic [7:0] delay_ticks,
   input  logic       abort,
   input  logic       door_lock,
   input  logic       motor_on,
   input  logic       drain_value_on,
   input  logic       done,
   output logic       start,
   output logic       cycle_timeout,
   output logic       spin_timeout,
   output logic       busy,
   output logic       prog_err,
   output logic       fault,
   output logic [1:0] phase
);

   localparam logic [7:0] WDOG_LIM = 8'(WDOG_TICKS);

   state_t     state, state_next;
   phase_t     phase_q, phase_next;
   logic [7:0] dly_cnt, dur_cnt, wd_cnt;
   logic [7:0] wash_t, rinse_t, spin_t;
   logic [7:0] cur_dur;
   logic       tick;
   logic       take_req, bad_req;
   logic       cycle_hit, spin_hit, wd_hit;
   logic       clr_dur, run_inc;
   logic       prog_err_q;

   wm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign take_req = (state == ST_IDLE) && prog_valid && !abort && (prog_sel != PROG_RSVD);
   assign bad_req  = (state == ST_IDLE) && prog_valid && !abort && (prog_sel == PROG_RSVD);
   assign cur_dur  = (phase_q == PH_RINSE) ? rinse_t : wash_t;

   // A phase ends on the tick that brings the elapsed count up to its duration.
   assign cycle_hit = (dur_cnt >= cur_dur) || (tick && (sat_inc(dur_cnt) >= cur_dur));
   assign spin_hit  = (dur_cnt >= spin_t)  || (tick && (sat_inc(dur_cnt) >= spin_t));
   assign wd_hit    = tick && (sat_inc(wd_cnt) >= WDOG_LIM);

   always_comb begin
      state_next = state;
      phase_next = phase_q;
      if (abort) begin
         state_next = ST_IDLE;
         phase_next = PH_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take_req) state_next = ST_DELAY;
            end
            ST_DELAY: begin
               if (dly_cnt == 8'd0) state_next = ST_START;
            end
            ST_START: begin
               if (door_lock) begin
                  state_next = ST_WAIT_MOTOR;
                  phase_next = PH_WASH;
               end
            end
            ST_WAIT_MOTOR: begin
               if (motor_on)    state_next = ST_RUN_CYCLE;
               else if (wd_hit) state_next = ST_FAULT;
            end
            ST_RUN_CYCLE: begin
               if (!motor_on)      state_next = ST_WAIT_MOTOR;
               else if (cycle_hit) state_next = ST_TIMEOUT_C;
            end
            ST_TIMEOUT_C: begin
               if (!motor_on) begin
                  if (phase_q == PH_WASH) begin
                     state_next = ST_WAIT_MOTOR;
                     phase_next = PH_RINSE;
                  end else begin
                     state_next = ST_WAIT_SPIN;
                     phase_next = PH_SPIN;
                  end
               end
            end
            ST_WAIT_SPIN: begin
               if (drain_value_on) state_next = ST_RUN_SPIN;
               else if (wd_hit)    state_next = ST_FAULT;
            end
            ST_RUN_SPIN: begin
               if (spin_hit) state_next = ST_TIMEOUT_S;
            end
            ST_TIMEOUT_S: begin
               if (done || !drain_value_on) begin
                  state_next = ST_IDLE;
                  phase_next = PH_IDLE;
               end
            end
            ST_FAULT: begin
               state_next = ST_FAULT;
            end
            default: begin
               state_next = ST_IDLE;
               phase_next = PH_IDLE;
            end
         endcase
      end
   end

   // The elapsed count is cleared only when a phase starts afresh, so a
   // motor dropout in RUN_CYCLE resumes from where it stopped.
   assign clr_dur = abort
                 || ((state == ST_START)     && (state_next == ST_WAIT_MOTOR))
                 || ((state == ST_TIMEOUT_C) && (state_next == ST_WAIT_MOTOR))
                 || ((state == ST_WAIT_SPIN) && (state_next == ST_RUN_SPIN));
   assign run_inc = tick && (((state == ST_RUN_CYCLE) && motor_on) || (state == ST_RUN_SPIN));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         phase_q    <= PH_IDLE;
         prog_err_q <= 1'b0;
      end else begin
         state      <= state_next;
         phase_q    <= phase_next;
         prog_err_q <= bad_req;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dly_cnt <= 8'd0;
         wash_t  <= 8'd0;
         rinse_t <= 8'd0;
         spin_t  <= 8'd0;
      end else if (take_req) begin
         dly_cnt <= delay_ticks;
         wash_t  <= WASH_T[prog_sel];
         rinse_t <= RINSE_T[prog_sel];
         spin_t  <= SPIN_T[prog_sel];
      end else if ((state == ST_DELAY) && tick) begin
         dly_cnt <= sat_dec(dly_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dur_cnt <= 8'd0;
      end else if (clr_dur) begin
         dur_cnt <= 8'd0;
      end else if (run_inc) begin
         dur_cnt <= sat_inc(dur_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= 8'd0;
      end else if (state_next != state) begin
         wd_cnt <= 8'd0;
      end else if (tick && ((state == ST_WAIT_MOTOR) || (state == ST_WAIT_SPIN))) begin
         wd_cnt <= sat_inc(wd_cnt);
      end
   end

   assign prog_ready    = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);
   assign start         = (state == ST_START);
   assign cycle_timeout = (state == ST_TIMEOUT_C);
   assign spin_timeout  = (state == ST_TIMEOUT_S);
   assign fault         = (state == ST_FAULT);
   assign prog_err      = prog_err_q;
   assign phase         = phase_q;

endmodule

// File: tb/tb_wm_scheduler.sv
// Directed bench for wm_scheduler with TICK_DIV=4 and a short watchdog.
// Phase lengths are predicted from a reference prescaler count kept by the bench.
module tb_wm_scheduler;

   localparam int TICK_DIV = 4;
   localparam int WDOG     = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       prog_valid, prog_ready;
   logic [1:0] prog_sel;
   logic [7:0] delay_ticks;
   logic       abort, door_lock, motor_on, drain_value_on, done;
   logic       start, cycle_timeout, spin_timeout, busy, prog_err, fault;
   logic [1:0] phase;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   wm_scheduler #(.TICK_DIV(TICK_DIV), .WDOG_TICKS(WDOG)) dut (
      .clk            (clk),
      .reset          (reset),
      .prog_valid     (prog_valid),
      .prog_ready     (prog_ready),
      .prog_sel       (prog_sel),
      .delay_ticks    (delay_ticks),
      .abort          (abort),
      .door_lock      (door_lock),
      .motor_on       (motor_on),
      .drain_value_on (drain_value_on),
      .done           (done),
      .start          (start),
      .cycle_timeout  (cycle_timeout),
      .spin_timeout   (spin_timeout),
      .busy           (busy),
      .prog_err       (prog_err),
      .fault          (fault),
      .phase          (phase)
   );

   always #5 clk = ~clk;

   // Reference prescaler: a tick occurs at the edge where cyc mod TICK_DIV = TICK_DIV-1.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int first_tick(input int c0);
      int k = 1;
      while (((c0 + k) % TICK_DIV) != (TICK_DIV - 1)) k++;
      return k;
   endfunction

   // Edges after the reference edge until the d-th tick has been taken.
   function automatic int ticks_to_edges(input int c0, input int d);
      return first_tick(c0) + TICK_DIV * (d - 1);
   endfunction

   function automatic logic sig_of(input int which);
      case (which)
         0:       return start;
         1:       return cycle_timeout;
         2:       return spin_timeout;
         3:       return fault;
         default: return 1'b0;
      endcase
   endfunction

   // Returns edges waited, or -1 when the bound runs out.
   task automatic wait_for(input int which, input int limit, output int n);
      bit found = 0;
      n = 0;
      while (!found && n < limit) begin
         step();
         n++;
         if (sig_of(which)) found = 1;
      end
      if (!found) n = -1;
   endtask

   task automatic accept(input logic [1:0] sel, input logic [7:0] d, output int c0);
      prog_valid  = 1'b1;
      prog_sel    = sel;
      delay_ticks = d;
      c0 = cyc;
      step();
      prog_valid = 1'b0;
   endtask

   initial begin
      int n, c0, hi_cnt;
      bit cto_seen;

      reset = 1'b1; prog_valid = 0; prog_sel = 0; delay_ticks = 0;
      abort = 0; door_lock = 0; motor_on = 0; drain_value_on = 0; done = 0;
      repeat (3) step();
      reset = 1'b0;
      repeat (20) step();

      check_val("rst_prog_ready", prog_ready, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_start", start, 0);
      check_val("rst_cycle_to", cycle_timeout, 0);
      check_val("rst_spin_to", spin_timeout, 0);
      check_val("rst_prog_err", prog_err, 0);
      check_val("rst_fault", fault, 0);
      check_val("rst_phase", phase, 0);

      // Reserved program is rejected with a single-cycle error pulse.
      accept(2'd3, 8'd0, c0);
      check_val("rsvd_err_pulse", prog_err, 1);
      check_val("rsvd_busy", busy, 0);
      check_val("rsvd_ready", prog_ready, 1);
      step();
      check_val("rsvd_err_clear", prog_err, 0);
      check_val("rsvd_still_idle", busy, 0);

      // Abort wins over a simultaneous request.
      abort = 1'b1;
      accept(2'd0, 8'd0, c0);
      abort = 1'b0;
      check_val("abort_vs_req_busy", busy, 0);
      check_val("abort_vs_req_ready", prog_ready, 1);
      step();
      check_val("abort_vs_req_settled", busy, 0);

      // Quick program, no delay, full cycle with a cooperating controller.
      accept(2'd1, 8'd0, c0);
      check_val("quick_busy", busy, 1);
      check_val("quick_ready_low", prog_ready, 0);
      wait_for(0, 20, n);
      check_val("quick_start_lat", n, 1);
      door_lock = 1'b1;
      step();
      check_val("quick_start_drop", start, 0);
      check_val("quick_phase_wash", phase, 1);
      motor_on = 1'b1;
      c0 = cyc;
      step();
      wait_for(1, 400, n);
      check_val("quick_wash_len", n, ticks_to_edges(c0, 15));
      motor_on = 1'b0;
      step();
      check_val("quick_cto_drop", cycle_timeout, 0);
      check_val("quick_phase_rinse", phase, 2);
      motor_on = 1'b1;
      c0 = cyc;
      step();
      wait_for(1, 400, n);
      check_val("quick_rinse_len", n, ticks_to_edges(c0, 8));
      motor_on = 1'b0;
      step();
      check_val("quick_phase_spin", phase, 3);
      drain_value_on = 1'b1;
      c0 = cyc;
      step();
      wait_for(2, 400, n);
      check_val("quick_spin_len", n, ticks_to_edges(c0, 10));
      done = 1'b1;
      step();
      check_val("quick_end_ready", prog_ready, 1);
      check_val("quick_end_busy", busy, 0);
      check_val("quick_end_sto", spin_timeout, 0);
      check_val("quick_end_phase", phase, 0);
      done = 0; drain_value_on = 0; door_lock = 0;
      step();

      // Normal program, 5-tick delay, door held open.
      accept(2'd0, 8'd5, c0);
      check_val("delay_phase0", phase, 0);
      wait_for(0, 100, n);
      check_val("delay_start_lat", n, ticks_to_edges(c0, 5) + 1);
      hi_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (start) hi_cnt++;
      end
      check_val("door_open_start_held", hi_cnt, 30);
      door_lock = 1'b1;
      c0 = cyc;
      step();
      check_val("door_lock_start_low", start, 0);
      check_val("door_lock_phase", phase, 1);

      // Controller never starts the motor: watchdog trips.
      wait_for(3, 200, n);
      check_val("wdog_latency", n, ticks_to_edges(c0, WDOG));
      check_val("fault_start_low", start, 0);
      check_val("fault_busy", busy, 1);
      repeat (5) step();
      check_val("fault_sticky", fault, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_val("fault_abort_clear", fault, 0);
      check_val("fault_abort_idle", prog_ready, 1);
      door_lock = 1'b0;
      step();

      // Heavy program aborted 30 ticks into the wash.
      accept(2'd2, 8'd0, c0);
      wait_for(0, 20, n);
      check_val("heavy_start_lat", n, 1);
      door_lock = 1'b1;
      step();
      motor_on = 1'b1;
      step();
      cto_seen = 0;
      for (int i = 0; i < 30 * TICK_DIV; i++) begin
         step();
         if (cycle_timeout) cto_seen = 1;
      end
      check_val("heavy_running", busy, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_val("heavy_abort_busy", busy, 0);
      check_val("heavy_abort_phase", phase, 0);
      check_val("heavy_abort_cto", cycle_timeout, 0);
      check_val("heavy_cto_never", cto_seen, 0);
      motor_on = 0; door_lock = 0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
